// File: rtl/led_pattern_gen_if.sv
// Control and LED-drive bundle for led_pattern_gen.
// The master side programs the sequencer; the slave side is the sequencer itself.
interface led_pattern_gen_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV_W = 24
);
    logic             en;
    logic             auto;
    logic [1:0]       mode;
    logic [DIV_W-1:0] div;
    logic [WIDTH-1:0] q;
    logic [1:0]       pat_id;
    logic             frame_done;

    modport master (
        output en, auto, mode, div,
        input  q, pat_id, frame_done
    );

    modport slave (
        input  en, auto, mode, div,
        output q, pat_id, frame_done
    );
endinterface

// File: rtl/led_pattern_gen.sv
// LED bar sequencer: four algorithmic patterns (chase-in, bloom, MSB bar, LSB bar),
// stepped by a programmable prescaler, in fixed-pattern or auto-cycle mode.
module led_pattern_gen #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV_W = 24
) (
    input logic              clk,
    input logic              rst,
    led_pattern_gen_if.slave bus
);
    localparam int LedCnt = int'(WIDTH);
    localparam int Half   = LedCnt / 2;
    localparam int StepW  = $clog2(2 * WIDTH);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [StepW-1:0] step_q, step_d;
    logic [1:0]       cur_pat_q, cur_pat_d;
    logic [1:0]       pat_id_q, pat_id_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             frame_done_q, frame_done_d;
    logic [1:0]       pat;
    logic             tick;
    logic             last;

    function automatic logic [StepW-1:0] last_step(input logic [1:0] p);
        case (p)
            2'd0:    return StepW'(Half + 1);
            2'd1:    return StepW'(LedCnt - 1);
            default: return StepW'(2 * LedCnt - 1);
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] pattern(input logic [1:0] p, input logic [StepW-1:0] idx);
        logic [WIDTH-1:0] v;
        int i;
        int n;
        int k;
        v = '0;
        i = int'(idx);
        // n: bar length for patterns 2/3; k: hole radius for the second half of bloom
        n = (i < LedCnt) ? i + 1 : 2 * LedCnt - 1 - i;
        k = i - Half;
        for (int b = 0; b < LedCnt; b++) begin
            case (p)
                2'd0: v[b] = (i >= 1) && (i <= Half) && ((b == LedCnt - i) || (b == i - 1));
                2'd1: begin
                    if (i < Half) v[b] = (b >= Half - 1 - i) && (b <= Half + i);
                    else          v[b] = !((b >= Half - 1 - k) && (b <= Half + k));
                end
                2'd2:    v[b] = (b >= LedCnt - n);
                default: v[b] = (b < n);
            endcase
        end
        return v;
    endfunction

    always_comb begin
        cnt_d        = cnt_q;
        step_d       = step_q;
        cur_pat_d    = cur_pat_q;
        pat_id_d     = pat_id_q;
        q_d          = q_q;
        frame_done_d = 1'b0;

        tick = bus.en && (cnt_q >= bus.div);
        // mode is only sampled at a frame start so a mid-frame change never truncates a frame
        pat  = ((step_q == '0) && !bus.auto) ? bus.mode : cur_pat_q;
        last = (step_q == last_step(pat));

        if (bus.en) cnt_d = cnt_q + 1'b1;
        if (tick) begin
            cnt_d     = '0;
            q_d       = pattern(pat, step_q);
            cur_pat_d = pat;
            pat_id_d  = pat;
            if (last) begin
                step_d       = '0;
                frame_done_d = 1'b1;
                if (bus.auto) cur_pat_d = pat + 2'd1;
            end else begin
                step_d = step_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            step_q       <= '0;
            cur_pat_q    <= '0;
            pat_id_q     <= '0;
            q_q          <= '0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            step_q       <= step_d;
            cur_pat_q    <= cur_pat_d;
            pat_id_q     <= pat_id_d;
            q_q          <= q_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.q          = q_q;
    assign bus.pat_id     = pat_id_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: WIDTH=8 full auto cycle, fixed mode with prescaler,
// enable freeze, async reset, prescaler reload, and a WIDTH=12 chase-in instance.
module tb_led_pattern_gen;
    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    led_pattern_gen_if #(.WIDTH(8),  .DIV_W(24)) bus8();
    led_pattern_gen_if #(.WIDTH(12), .DIV_W(24)) bus12();

    led_pattern_gen #(.WIDTH(8),  .DIV_W(24)) dut8  (.clk(clk), .rst(rst), .bus(bus8));
    led_pattern_gen #(.WIDTH(12), .DIV_W(24)) dut12 (.clk(clk), .rst(rst), .bus(bus12));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference 8-LED sequence: chase-in, bloom, MSB bar, LSB bar
    logic [7:0] seq8 [46] = '{
        8'h00, 8'h81, 8'h42, 8'h24, 8'h18, 8'h00,
        8'h18, 8'h3C, 8'h7E, 8'hFF, 8'hE7, 8'hC3, 8'h81, 8'h00,
        8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF,
        8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00,
        8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
        8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00
    };
    logic [11:0] seq12 [8] = '{
        12'h000, 12'h801, 12'h402, 12'h204, 12'h108, 12'h090, 12'h060, 12'h000
    };

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b0;
        bus8.en    = 1'b1;
        bus8.auto  = 1'b1;
        bus8.mode  = 2'd0;
        bus8.div   = 24'd0;
        bus12.en   = 1'b1;
        bus12.auto = 1'b0;
        bus12.mode = 2'd0;
        bus12.div  = 24'd0;

        // Reset state
        cyc(2);
        chk("rst q", bus8.q, 8'h00);
        chk("rst pat_id", bus8.pat_id, 2'd0);
        chk("rst frame_done", bus8.frame_done, 1'b0);

        // Full auto cycle, tick every clock
        rst = 1'b1;
        for (int k = 0; k < 46; k++) begin
            cyc(1);
            chk($sformatf("auto q[%0d]", k), bus8.q, seq8[k]);
            chk($sformatf("auto pat_id[%0d]", k), bus8.pat_id,
                (k < 6) ? 2'd0 : (k < 14) ? 2'd1 : (k < 30) ? 2'd2 : 2'd3);
            chk($sformatf("auto frame_done[%0d]", k), bus8.frame_done,
                (k == 5) || (k == 13) || (k == 29) || (k == 45));
        end
        cyc(1);
        chk("wrap q", bus8.q, 8'h00);
        chk("wrap pat_id", bus8.pat_id, 2'd0);
        chk("wrap frame_done", bus8.frame_done, 1'b0);
        cyc(1);
        chk("wrap q step1", bus8.q, 8'h81);

        // Fixed mode 2, div=3: step every 4 clocks
        rst       = 1'b0;
        bus8.auto = 1'b0;
        bus8.mode = 2'd2;
        bus8.div  = 24'd3;
        cyc(1);
        rst = 1'b1;
        cyc(3);
        chk("div3 pre-tick q", bus8.q, 8'h00);
        for (int s = 0; s < 16; s++) begin
            if (s > 0) begin
                cyc(3);
                chk($sformatf("div3 hold[%0d]", s), bus8.q, seq8[13+s]);
            end
            cyc(1);
            chk($sformatf("div3 q[%0d]", s), bus8.q, seq8[14+s]);
            chk($sformatf("div3 pat_id[%0d]", s), bus8.pat_id, 2'd2);
            chk($sformatf("div3 frame_done[%0d]", s), bus8.frame_done, s == 15);
        end
        cyc(1);
        chk("div3 frame_done fall", bus8.frame_done, 1'b0);
        chk("div3 q held", bus8.q, 8'h00);
        cyc(3);
        chk("repeat q[0]", bus8.q, 8'h80);
        for (int s = 1; s < 6; s++) begin
            cyc(4);
            chk($sformatf("repeat q[%0d]", s), bus8.q, seq8[14+s]);
        end
        // Mode change mid-frame must wait for the frame end
        bus8.mode = 2'd1;
        for (int s = 6; s < 16; s++) begin
            cyc(4);
            chk($sformatf("modechg q[%0d]", s), bus8.q, seq8[14+s]);
            chk($sformatf("modechg pat_id[%0d]", s), bus8.pat_id, 2'd2);
        end
        cyc(4);
        chk("new frame q", bus8.q, 8'h18);
        chk("new frame pat_id", bus8.pat_id, 2'd1);
        cyc(4);
        chk("new frame q step1", bus8.q, 8'h3C);

        // Enable freeze with prescaler phase at 2
        cyc(2);
        bus8.en = 1'b0;
        cyc(10);
        chk("freeze q", bus8.q, 8'h3C);
        chk("freeze pat_id", bus8.pat_id, 2'd1);
        bus8.en = 1'b1;
        cyc(1);
        chk("resume phase q", bus8.q, 8'h3C);
        cyc(1);
        chk("resume q", bus8.q, 8'h7E);

        // Asynchronous reset between edges
        rst = 1'b0;
        #1;
        chk("async rst q", bus8.q, 8'h00);
        chk("async rst pat_id", bus8.pat_id, 2'd0);
        chk("async rst frame_done", bus8.frame_done, 1'b0);
        bus8.auto = 1'b1;
        bus8.div  = 24'd0;
        #1;
        rst = 1'b1;
        cyc(1);
        chk("restart q[0]", bus8.q, 8'h00);
        chk("restart pat_id", bus8.pat_id, 2'd0);
        cyc(1);
        chk("restart q[1]", bus8.q, 8'h81);
        cyc(1);
        chk("restart q[2]", bus8.q, 8'h42);

        // Lowering div below the running count ticks on the next enabled edge
        rst       = 1'b0;
        bus8.auto = 1'b0;
        bus8.mode = 2'd1;
        bus8.div  = 24'd10;
        cyc(1);
        rst = 1'b1;
        cyc(5);
        chk("div10 no tick", bus8.q, 8'h00);
        bus8.div = 24'd2;
        cyc(1);
        chk("div lowered tick", bus8.q, 8'h18);
        cyc(2);
        chk("div2 hold", bus8.q, 8'h18);
        cyc(1);
        chk("div2 tick", bus8.q, 8'h3C);

        // WIDTH=12 chase-in, repeating every 8 ticks
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
        for (int k = 0; k < 16; k++) begin
            cyc(1);
            chk($sformatf("w12 q[%0d]", k), bus12.q, seq12[k%8]);
            chk($sformatf("w12 frame_done[%0d]", k), bus12.frame_done, (k % 8) == 7);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
